hard_loader: RTL and testbench
==============================

Name: hard_loader

Overview:
- Sequencer that drives the `hard` FIR filter's load protocol from streaming valid/ready inputs and returns the filter result on a valid/ready output.
- Per frame it pulses the filter reset, then shifts TAPS coefficients plus one scaling word on the coefficient strobe, then TAPS samples on the sample strobe.
- It then waits a settle time and captures the filter output.
- It sits between the host/DMA stream and the `hard` instance, in the same clock domain.

Parameters:
- WIDTH, 32, data width of stream words, filt_in and filt_out.
- TAPS, 64, number of coefficients and samples per frame.
- RST_CYC, 2, cycles filt_reset is held high at frame start.
- SETTLE_CYC, 4, cycles waited after the last sample strobe falls before capturing filt_out.
- RES_MAX, 511, magnitude limit used by the optional overflow flag.

Ports:
- clk  in  1  single system clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse; starts a frame when IDLE.
- busy  out  1  high in every state except IDLE.
- s_data  in  WIDTH  input word: coefficient/scale in Q.11, or sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- filt_reset  out  1  to filter reset, active-high.
- clk_coeff  out  1  coefficient strobe to filter.
- clk_sample  out  1  sample strobe to filter.
- filt_in  out  WIDTH  to filter in.
- filt_out  in  WIDTH  from filter out.
- m_data  out  WIDTH  captured result.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts m_data.
- m_ovf  out  1  result overflow flag, qualified by m_valid.

Behaviour:
- Reset (reset_n low, any time, including mid-frame):
  - State is IDLE; cnt=0; ph=0.
  - All outputs are 0: busy, s_ready, filt_reset, clk_coeff, clk_sample, filt_in, m_data, m_valid, m_ovf.
  - A partially loaded frame is discarded.
- All outputs are registered, except s_ready, which is decoded from state and ph.
- States:
  - IDLE: cfg_start goes to FRST. cfg_start is ignored in every other state.
  - FRST: filt_reset=1 for exactly RST_CYC cycles, then COEF. ph=0, cnt=0.
  - COEF: transfers TAPS+1 words; words 0..TAPS-1 are coefficients, word TAPS is the scale. After the strobe of word TAPS falls, go to SAMP with cnt=0.
  - SAMP: transfers TAPS words on clk_sample. After the last strobe falls, go to SETTLE.
  - SETTLE: counts SETTLE_CYC cycles, then m_data<=filt_out, m_valid<=1, go to RESULT.
  - RESULT: holds m_data/m_valid until m_valid&&m_ready, then m_valid=0 the next cycle and return to IDLE.
- Word transfer (COEF/SAMP), two-phase ph toggle:
  - ph=0: s_ready=1, strobe=0. On s_valid&&s_ready, filt_in<=s_data and ph<=1.
  - ph=1: s_ready=0, strobe=1 for one cycle, cnt++, ph<=0.
  - filt_in is therefore stable one full cycle before the strobe rises and through the whole strobe-high cycle.
  - Minimum period is 2 cycles per word. s_valid low stalls in ph=0 with the strobe low.
- clk_coeff and clk_sample are never high in the same cycle. Each rises only in ph=1 of its own state.
- filt_in holds its last value outside COEF/SAMP.
- Strobe counts per frame are exactly TAPS+1 on clk_coeff and TAPS on clk_sample.
- s_ready=0 in IDLE, FRST, SETTLE and RESULT; words offered there are not consumed.
- m_data is a raw copy of filt_out; no arithmetic is applied.
- A new cfg_start can only take effect in IDLE, i.e. after the result handshake.

Optional Feature:
- Macro HARD_LOADER_OVF_EN.
- Defined: at capture, m_ovf<=1 if $signed(filt_out) > RES_MAX or < -RES_MAX, else 0. m_ovf is held with m_data and cleared with m_valid.
- Undefined: m_ovf is constant 0 and the comparator is not built.

Test Plan:
- Basic frame, bench `hard` model attached:
  - Stimulus: cfg_start, 64 coeffs of 2048 (1.0), scale 1024 (0.5), 64 samples of 1, s_valid always high, m_ready=1.
  - Required: filt_reset high 2 cycles; 65 clk_coeff pulses then 64 clk_sample pulses; each word period 2 cycles; m_data=32 with m_valid one cycle after the 4th settle cycle.
- Ordering and stall:
  - Stimulus: coeff words 0..64 with s_valid dropped for 3 cycles after word 10.
  - Required: filt_in at each clk_coeff rise equals the word index; no strobe during the stall; total clk_coeff count is 65.
- Backpressure:
  - Stimulus: m_ready=0 for 20 cycles after m_valid.
  - Required: m_data and m_valid stable; cfg_start pulses in this window ignored; s_ready=0; IDLE one cycle after the handshake.
- Reset mid-frame:
  - Stimulus: reset_n low during sample 30.
  - Required: all outputs 0 asynchronously. A fresh frame (coeff 2048, scale 1024, samples 1) then yields m_data=32.
- Overflow flag (HARD_LOADER_OVF_EN defined):
  - Stimulus: model returns filt_out=600, then -512, then 511.
  - Required: m_ovf=1, 1, 0 respectively.
- Overflow flag (HARD_LOADER_OVF_EN undefined):
  - Stimulus: same model returning filt_out=600.
  - Required: m_ovf=0.

Source files
------------

// File: rtl/hard_loader.sv
// Load sequencer for the `hard` FIR filter: reset pulse, TAPS coefficients plus scale, TAPS samples, settle, capture.
// Optional overflow flag on the captured result is built when HARD_LOADER_OVF_EN is defined.
module hard_loader #(
  parameter int WIDTH      = 32,
  parameter int TAPS       = 64,
  parameter int RST_CYC    = 2,
  parameter int SETTLE_CYC = 4,
  parameter int RES_MAX    = 511
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_start,
  output logic             busy,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             filt_reset,
  output logic             clk_coeff,
  output logic             clk_sample,
  output logic [WIDTH-1:0] filt_in,
  input  logic [WIDTH-1:0] filt_out,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_ovf
);

  localparam int CNT_W = $clog2(TAPS + RST_CYC + SETTLE_CYC + 2);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TAPS  = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0] C_TAPS1 = CNT_W'(TAPS + 1);
  localparam logic [CNT_W-1:0] C_RST_L = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] C_SET_L = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FRST, S_COEF, S_SAMP, S_SETTLE, S_RESULT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ph, w_ph_nxt;
  logic             r_busy, r_filt_reset, r_clk_coeff, r_clk_sample, r_m_valid, r_m_ovf;
  logic             w_busy_nxt, w_filt_reset_nxt, w_clk_coeff_nxt, w_clk_sample_nxt;
  logic             w_m_valid_nxt, w_m_ovf_nxt;
  logic [WIDTH-1:0] r_filt_in, r_m_data, w_filt_in_nxt, w_m_data_nxt;
  logic             w_s_ready;
  logic             w_ovf;

`ifdef HARD_LOADER_OVF_EN
  localparam logic signed [WIDTH-1:0] LIM = WIDTH'(RES_MAX);
  logic signed [WIDTH-1:0] w_res_s;
  assign w_res_s = filt_out;
  assign w_ovf   = (w_res_s > LIM) || (w_res_s < -LIM);
`else
  assign w_ovf = 1'b0;
`endif

  // COEF accepts TAPS+1 words (last one is the scale); the extra count value is the final strobe cycle.
  assign w_s_ready = !r_ph && (((r_state == S_COEF) && (r_cnt <= C_TAPS)) ||
                               ((r_state == S_SAMP) && (r_cnt <  C_TAPS)));

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_ph_nxt         = r_ph;
    w_filt_in_nxt    = r_filt_in;
    w_m_data_nxt     = r_m_data;
    w_m_valid_nxt    = r_m_valid;
    w_m_ovf_nxt      = r_m_ovf;
    w_filt_reset_nxt = 1'b0;
    w_clk_coeff_nxt  = 1'b0;
    w_clk_sample_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_state_nxt      = S_FRST;
          w_cnt_nxt        = '0;
          w_ph_nxt         = 1'b0;
          w_filt_reset_nxt = 1'b1;
        end
      end
      S_FRST: begin
        if (r_cnt == C_RST_L) begin
          w_state_nxt = S_COEF;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt        = r_cnt + C_ONE;
          w_filt_reset_nxt = 1'b1;
        end
      end
      S_COEF, S_SAMP: begin
        if (r_ph) begin
          // filt_in was loaded last cycle, so the strobe rises on already-stable data.
          w_ph_nxt         = 1'b0;
          w_cnt_nxt        = r_cnt + C_ONE;
          w_clk_coeff_nxt  = (r_state == S_COEF);
          w_clk_sample_nxt = (r_state == S_SAMP);
        end else if (w_s_ready && s_valid) begin
          w_filt_in_nxt = s_data;
          w_ph_nxt      = 1'b1;
        end else if ((r_state == S_COEF) && (r_cnt == C_TAPS1)) begin
          w_state_nxt = S_SAMP;
          w_cnt_nxt   = '0;
        end else if ((r_state == S_SAMP) && (r_cnt == C_TAPS)) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == C_SET_L) begin
          w_m_data_nxt  = filt_out;
          w_m_valid_nxt = 1'b1;
          w_m_ovf_nxt   = w_ovf;
          w_state_nxt   = S_RESULT;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_RESULT: begin
        if (r_m_valid && m_ready) begin
          w_m_valid_nxt = 1'b0;
          w_m_ovf_nxt   = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_ph_nxt    = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ph         <= 1'b0;
      r_busy       <= 1'b0;
      r_filt_reset <= 1'b0;
      r_clk_coeff  <= 1'b0;
      r_clk_sample <= 1'b0;
      r_filt_in    <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_ovf      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ph         <= w_ph_nxt;
      r_busy       <= w_busy_nxt;
      r_filt_reset <= w_filt_reset_nxt;
      r_clk_coeff  <= w_clk_coeff_nxt;
      r_clk_sample <= w_clk_sample_nxt;
      r_filt_in    <= w_filt_in_nxt;
      r_m_data     <= w_m_data_nxt;
      r_m_valid    <= w_m_valid_nxt;
      r_m_ovf      <= w_m_ovf_nxt;
    end
  end

  assign busy       = r_busy;
  assign s_ready    = w_s_ready;
  assign filt_reset = r_filt_reset;
  assign clk_coeff  = r_clk_coeff;
  assign clk_sample = r_clk_sample;
  assign filt_in    = r_filt_in;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_ovf      = r_m_ovf;

endmodule

// File: tb/tb_hard_loader.sv
// Self-checking bench for hard_loader with a behavioural `hard` filter model driving filt_out.
module tb_hard_loader;
  localparam int WIDTH = 32, TAPS = 64, RST_CYC = 2, SETTLE_CYC = 4, RES_MAX = 511;

  logic clk = 1'b0;
  logic reset_n, cfg_start, s_valid, m_ready;
  logic [WIDTH-1:0] s_data, filt_out;
  logic busy, s_ready, filt_reset, clk_coeff, clk_sample, m_valid, m_ovf;
  logic [WIDTH-1:0] filt_in, m_data;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  hard_loader #(.WIDTH(WIDTH), .TAPS(TAPS), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC),
                .RES_MAX(RES_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .busy(busy),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .filt_reset(filt_reset), .clk_coeff(clk_coeff), .clk_sample(clk_sample),
    .filt_in(filt_in), .filt_out(filt_out),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_ovf(m_ovf));

  // Filter model and strobe monitor, sampled on the falling edge.
  longint cyc = 0;
  int frst_len = 0, c_idx = 0, s_idx = 0, both_hi = 0;
  int c_log[0:TAPS];
  int s_log[0:TAPS-1];
  longint c_cyc[0:TAPS];
  longint s_cyc[0:TAPS-1];
  longint mv_cyc = -1;
  logic fr_prev = 1'b0, mv_prev = 1'b0;
  logic ovr_en = 1'b0;
  int ovr_val = 0;
  longint m_acc, m_res;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin c_idx = 0; s_idx = 0; end
    if (filt_reset) begin
      if (!fr_prev) begin frst_len = 0; c_idx = 0; s_idx = 0; both_hi = 0; mv_cyc = -1; end
      frst_len = frst_len + 1;
    end
    fr_prev = filt_reset;
    if (clk_coeff && clk_sample) both_hi = both_hi + 1;
    if (clk_coeff) begin
      if (c_idx <= TAPS) begin c_log[c_idx] = int'(filt_in); c_cyc[c_idx] = cyc; end
      c_idx = c_idx + 1;
    end
    if (clk_sample) begin
      if (s_idx < TAPS) begin s_log[s_idx] = int'(filt_in); s_cyc[s_idx] = cyc; end
      s_idx = s_idx + 1;
    end
    if (m_valid && !mv_prev) mv_cyc = cyc;
    mv_prev = m_valid;
    m_acc = 0;
    for (int i = 0; i < TAPS; i++) m_acc += longint'(c_log[i]) * longint'(s_log[i]);
    m_res = ((m_acc >>> 11) * longint'(c_log[TAPS])) >>> 11;
    filt_out = ovr_en ? WIDTH'(ovr_val) : m_res[WIDTH-1:0];
  end

  // Frame content offered by the bench: coefficients 0..TAPS-1, scale at TAPS, then samples.
  int tb_c[0:TAPS];
  int tb_s[0:TAPS-1];

  function automatic int exp_result();
    longint acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(tb_c[i]) * longint'(tb_s[i]);
    return int'(((acc >>> 11) * longint'(tb_c[TAPS])) >>> 11);
  endfunction

  function automatic logic exp_ovf(input int v);
`ifdef HARD_LOADER_OVF_EN
    return (v > RES_MAX) || (v < -RES_MAX);
`else
    return 1'b0;
`endif
  endfunction

  task automatic fill_basic();
    for (int i = 0; i < TAPS; i++) begin tb_c[i] = 2048; tb_s[i] = 1; end
    tb_c[TAPS] = 1024;
  endtask

  task automatic fill_random();
    for (int i = 0; i < TAPS; i++) begin
      tb_c[i] = int'($urandom_range(8191)) - 4096;
      tb_s[i] = int'($urandom_range(2000)) - 1000;
    end
    tb_c[TAPS] = int'($urandom_range(4095));
  endtask

  task automatic start_frame();
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
  endtask

  task automatic feed(input int max_words, input int stall_at, input int stall_len, input int rnd_pct);
    int k = 0, stall = 0, budget = 5000;
    while (k < max_words && budget > 0) begin
      @(negedge clk); budget--;
      if (stall > 0) begin s_valid = 1'b0; stall--; end
      else if (rnd_pct > 0 && int'($urandom_range(99)) < rnd_pct) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_data  = (k <= TAPS) ? WIDTH'(tb_c[k]) : WIDTH'(tb_s[k-TAPS-1]);
      end
      if (s_valid && s_ready) begin
        if (k == stall_at) stall = stall_len;
        k++;
      end
    end
    @(negedge clk); s_valid = 1'b0;
    checks++;
    if (k != max_words) begin
      errors++; $display("FAIL feed_timeout: accepted %0d words, required %0d", k, max_words);
    end
  endtask

  task automatic wait_mvalid();
    int budget = 200;
    while (!m_valid && budget > 0) begin @(negedge clk); budget--; end
    #1;
    checks++;
    if (!m_valid) begin errors++; $display("FAIL mvalid_timeout: m_valid=%0b required 1", m_valid); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cfg_start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, s_ready, filt_reset, clk_coeff, clk_sample, filt_in, m_data, m_valid, m_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b s_ready=%0b frst=%0b cc=%0b cs=%0b fin=%h md=%h mv=%0b ovf=%0b required all 0",
               busy, s_ready, filt_reset, clk_coeff, clk_sample, filt_in, m_data, m_valid, m_ovf);
    end
    reset_n = 1'b1;
    @(negedge clk); s_valid = 1'b1; s_data = 32'h55;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || clk_coeff !== 1'b0) begin
      errors++; $display("FAIL idle_no_accept: s_ready=%0b busy=%0b clk_coeff=%0b required 0 0 0", s_ready, busy, clk_coeff);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_basic();
    int bad = 0;
    fill_basic(); m_ready = 1'b1;
    start_frame();
    feed(2*TAPS+1, -1, 0, 0);
    wait_mvalid();
    checks++;
    if (m_data !== 32'd32) begin errors++; $display("FAIL basic_result: m_data=%0d required 32", m_data); end
    checks++;
    if (frst_len != RST_CYC) begin errors++; $display("FAIL basic_frst_len: %0d cycles required %0d", frst_len, RST_CYC); end
    checks++;
    if (c_idx != TAPS+1 || s_idx != TAPS) begin
      errors++; $display("FAIL basic_strobe_count: coeff=%0d sample=%0d required %0d %0d", c_idx, s_idx, TAPS+1, TAPS);
    end
    for (int k = 1; k <= TAPS; k++) if (c_cyc[k] - c_cyc[k-1] != 2) bad++;
    for (int k = 1; k < TAPS; k++) if (s_cyc[k] - s_cyc[k-1] != 2) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_word_period: %0d gaps not 2 cycles, required 0", bad); end
    checks++;
    if (mv_cyc - s_cyc[TAPS-1] != SETTLE_CYC + 1) begin
      errors++; $display("FAIL basic_settle_latency: %0d cycles required %0d", mv_cyc - s_cyc[TAPS-1], SETTLE_CYC + 1);
    end
    checks++;
    if (both_hi != 0) begin errors++; $display("FAIL basic_strobe_overlap: %0d cycles required 0", both_hi); end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_handshake: m_valid=%0b busy=%0b required 0 0", m_valid, busy);
    end
  endtask

  task automatic test_order_stall();
    int bad = 0;
    fill_random();
    for (int i = 0; i <= TAPS; i++) tb_c[i] = i;
    m_ready = 1'b1;
    start_frame();
    feed(2*TAPS+1, 10, 3, 0);
    wait_mvalid();
    for (int k = 0; k <= TAPS; k++) if (c_log[k] != k) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL order_filt_in: %0d words out of order, required 0", bad); end
    checks++;
    if (c_idx != TAPS+1) begin errors++; $display("FAIL order_coeff_count: %0d required %0d", c_idx, TAPS+1); end
    bad = 0;
    for (int k = 1; k <= TAPS; k++) if (c_cyc[k] - c_cyc[k-1] != ((k == 11) ? 4 : 2)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL order_stall_timing: %0d gaps wrong, required 0", bad); end
    checks++;
    if (m_data !== WIDTH'(exp_result())) begin
      errors++; $display("FAIL order_result: m_data=%0d required %0d", $signed(m_data), exp_result());
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    logic [WIDTH-1:0] d0;
    fill_random(); m_ready = 1'b0;
    start_frame();
    feed(2*TAPS+1, -1, 0, 30);
    wait_mvalid();
    d0 = m_data;
    checks++;
    if (d0 !== WIDTH'(exp_result())) begin
      errors++; $display("FAIL bp_result: m_data=%0d required %0d", $signed(d0), exp_result());
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cfg_start = (i % 5 == 0); s_valid = 1'b1; s_data = $urandom;
      if (m_data !== d0 || m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1 || filt_reset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
    @(negedge clk); cfg_start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_idle_after_hs: m_valid=%0b busy=%0b required 0 0", m_valid, busy);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (busy !== 1'b0 || filt_reset !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_start_ignored: %0d busy cycles, required 0", bad); end
  endtask

  task automatic test_reset_mid();
    fill_basic(); m_ready = 1'b1;
    start_frame();
    feed(TAPS+1+31, -1, 0, 0);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, s_ready, filt_reset, clk_coeff, clk_sample, filt_in, m_data, m_valid, m_ovf} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%0b s_ready=%0b frst=%0b cc=%0b cs=%0b fin=%h mv=%0b required all 0",
               busy, s_ready, filt_reset, clk_coeff, clk_sample, filt_in, m_valid);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    start_frame();
    feed(2*TAPS+1, -1, 0, 0);
    wait_mvalid();
    checks++;
    if (m_data !== 32'd32 || c_idx != TAPS+1 || s_idx != TAPS) begin
      errors++; $display("FAIL midreset_fresh_frame: m_data=%0d coeff=%0d sample=%0d required 32 %0d %0d",
                         m_data, c_idx, s_idx, TAPS+1, TAPS);
    end
    @(negedge clk);
  endtask

  task automatic test_ovf();
    int vals[5] = '{600, -512, 511, -511, 512};
    fill_basic(); m_ready = 1'b1; ovr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ovr_val = vals[i];
      start_frame();
      feed(2*TAPS+1, -1, 0, 0);
      wait_mvalid();
      checks++;
      if (m_data !== WIDTH'(vals[i]) || m_ovf !== exp_ovf(vals[i])) begin
        errors++; $display("FAIL ovf_flag_%0d: m_data=%0d m_ovf=%0b required %0d %0b",
                           vals[i], $signed(m_data), m_ovf, vals[i], exp_ovf(vals[i]));
      end
      @(negedge clk);
      checks++;
      if (m_ovf !== 1'b0 || m_valid !== 1'b0) begin
        errors++; $display("FAIL ovf_clear_%0d: m_ovf=%0b m_valid=%0b required 0 0", vals[i], m_ovf, m_valid);
      end
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_random();
    int e;
    for (int f = 0; f < 3; f++) begin
      fill_random(); m_ready = 1'b0;
      start_frame();
      feed(2*TAPS+1, -1, 0, 25);
      wait_mvalid();
      e = exp_result();
      checks++;
      if (m_data !== WIDTH'(e) || m_ovf !== exp_ovf(e) || both_hi != 0 || c_idx != TAPS+1 || s_idx != TAPS) begin
        errors++; $display("FAIL random_frame_%0d: m_data=%0d ovf=%0b overlap=%0d cc=%0d cs=%0d required %0d %0b 0 %0d %0d",
                           f, $signed(m_data), m_ovf, both_hi, c_idx, s_idx, e, exp_ovf(e), TAPS+1, TAPS);
      end
      repeat ($urandom_range(5)) @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk); m_ready = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL random_handshake_%0d: m_valid=%0b busy=%0b required 0 0", f, m_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order_stall();
    test_backpressure();
    test_reset_mid();
    test_ovf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
